ldm_stm_seq: RTL and testbench



---
 rtl/ldm_stm_seq_pkg.sv | 22 ++
 rtl/ldm_stm_seq_if.sv | 31 +++
 rtl/ldm_stm_seq_lowest_set_bit.sv | 14 +
 rtl/ldm_stm_seq.sv | 186 ++++++++++++++++++
 tb/tb_ldm_stm_seq.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/ldm_stm_seq_pkg.sv
// Shared types and constants for the LDM/STM block-transfer sequencer.
package ldm_stm_seq_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      XFER  = 3'd2,
      LDWR  = 3'd3,
      WB    = 3'd4,
      DONE  = 3'd5
   } state_t;

   localparam logic [3:0] PC_IDX     = 4'd15;
   localparam int         WORD_BYTES = 4;

   // Addressing-mode codes, encoded as {pre, up}
   localparam logic [1:0] DA = 2'b00;
   localparam logic [1:0] IA = 2'b01;
   localparam logic [1:0] DB = 2'b10;
   localparam logic [1:0] IB = 2'b11;

endpackage

// File: rtl/ldm_stm_seq_if.sv
// Register-file and data-memory port bundle driven by the LDM/STM sequencer.
interface ldm_stm_seq_if #(
   parameter int ADDR = 4,
   parameter int SIZE = 32
);
   logic [ADDR-1:0] rf_raddr;
   logic [SIZE-1:0] rf_rdata;
   logic [ADDR-1:0] rf_waddr;
   logic [SIZE-1:0] rf_wdata;
   logic            rf_we;
   logic            pc_we;
   logic [SIZE-1:0] pc_new;
   logic            mem_req;
   logic            mem_we;
   logic [SIZE-1:0] mem_addr;
   logic [SIZE-1:0] mem_wdata;
   logic            mem_ack;
   logic [SIZE-1:0] mem_rdata;

   modport master (
      output rf_raddr, rf_waddr, rf_wdata, rf_we, pc_we, pc_new,
             mem_req, mem_we, mem_addr, mem_wdata,
      input  rf_rdata, mem_ack, mem_rdata
   );

   modport slave (
      input  rf_raddr, rf_waddr, rf_wdata, rf_we, pc_we, pc_new,
             mem_req, mem_we, mem_addr, mem_wdata,
      output rf_rdata, mem_ack, mem_rdata
   );
endinterface

// File: rtl/ldm_stm_seq_lowest_set_bit.sv
// 16-bit priority encoder: index of the lowest set bit plus a non-empty flag.
module lowest_set_bit (
   input  logic [15:0] i_vec,
   output logic [3:0]  o_idx,
   output logic        o_vld
);
   always_comb begin
      o_idx = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (i_vec[i]) o_idx = 4'(i);
      end
      o_vld = |i_vec;
   end
endmodule

// File: rtl/ldm_stm_seq.sv
// LDM/STM sequencer: walks the register list lowest-first, one word per memory
// handshake, then optionally writes back the base register.
module ldm_stm_seq
   import ldm_stm_seq_pkg::*;
#(
   parameter int ADDR = 4,
   parameter int SIZE = 32
) (
   input  logic             clk,
   input  logic             Rst,
   input  logic             i_start,
   input  logic             i_is_load,
   input  logic             i_pre,
   input  logic             i_up,
   input  logic             i_wback,
   input  logic [ADDR-1:0]  i_rn_addr,
   input  logic [SIZE-1:0]  i_rn_data,
   input  logic [15:0]      i_reg_list,
   ldm_stm_seq_if.master    bus,
   output logic             o_busy,
   output logic             o_done
);
   localparam logic [SIZE-1:0] STEP = SIZE'(WORD_BYTES);

   state_t          r_state;
   logic            r_is_load;
   logic [1:0]      r_mode;
   logic            r_do_wb;
   logic [ADDR-1:0] r_rn_addr;
   logic [SIZE-1:0] r_base;
   logic [SIZE-1:0] r_final;
   logic [15:0]     r_list;
   logic [SIZE-1:0] r_addr;
   logic            r_mem_req;
   logic            r_mem_we;
   logic            r_rf_we;
   logic [ADDR-1:0] r_rf_waddr;
   logic [SIZE-1:0] r_rf_wdata;
   logic            r_pc_we;
   logic [SIZE-1:0] r_pc_new;
   logic            r_busy;
   logic            r_done;

   logic [3:0]      w_cur_idx;
   logic            w_cur_vld;
   logic [15:0]     w_list_nxt;
   logic [4:0]      w_cnt;
   logic [SIZE-1:0] w_span;
   logic [SIZE-1:0] w_start_addr;

   lowest_set_bit u_lsb (
      .i_vec (r_list),
      .o_idx (w_cur_idx),
      .o_vld (w_cur_vld)
   );

   always_comb begin
      w_cnt = 5'd0;
      for (int i = 0; i < 16; i++) w_cnt = w_cnt + {4'd0, r_list[i]};
      w_span     = {{(SIZE-7){1'b0}}, w_cnt, 2'b00};
      w_list_nxt = r_list & ~(16'b1 << w_cur_idx);
      case (r_mode)
         IA:      w_start_addr = r_base;
         IB:      w_start_addr = r_base + STEP;
         DA:      w_start_addr = r_base - w_span + STEP;
         default: w_start_addr = r_base - w_span;
      endcase
   end

   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) begin
         r_state    <= IDLE;
         r_is_load  <= 1'b0;
         r_mode     <= 2'b00;
         r_do_wb    <= 1'b0;
         r_rn_addr  <= '0;
         r_base     <= '0;
         r_final    <= '0;
         r_list     <= '0;
         r_addr     <= '0;
         r_mem_req  <= 1'b0;
         r_mem_we   <= 1'b0;
         r_rf_we    <= 1'b0;
         r_rf_waddr <= '0;
         r_rf_wdata <= '0;
         r_pc_we    <= 1'b0;
         r_pc_new   <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_rf_we <= 1'b0;
         r_pc_we <= 1'b0;
         r_done  <= 1'b0;
         case (r_state)
            IDLE: if (i_start) begin
               r_is_load <= i_is_load;
               r_mode    <= {i_pre, i_up};
               // Loading the base register overrides writeback; so does a PC base
               r_do_wb   <= i_wback && (i_rn_addr != ADDR'(PC_IDX)) &&
                            !(i_is_load && i_reg_list[i_rn_addr]);
               r_rn_addr <= i_rn_addr;
               r_base    <= i_rn_data;
               r_list    <= i_reg_list;
               r_busy    <= 1'b1;
               r_state   <= SETUP;
            end
            SETUP: begin
               r_final <= r_mode[0] ? r_base + w_span : r_base - w_span;
               r_addr  <= w_start_addr;
               if (w_cur_vld) begin
                  r_mem_req <= 1'b1;
                  r_mem_we  <= !r_is_load;
                  r_state   <= XFER;
               end else begin
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end
            end
            XFER: if (bus.mem_ack) begin
               r_list <= w_list_nxt;
               r_addr <= r_addr + STEP;
               if (r_is_load) begin
                  r_mem_req <= 1'b0;
                  r_state   <= LDWR;
                  if (w_cur_idx == PC_IDX) begin
                     r_pc_we  <= 1'b1;
                     r_pc_new <= bus.mem_rdata & ~SIZE'(3);
                  end else begin
                     r_rf_we    <= 1'b1;
                     r_rf_waddr <= ADDR'(w_cur_idx);
                     r_rf_wdata <= bus.mem_rdata;
                  end
               end else if (w_list_nxt == 16'd0) begin
                  r_mem_req <= 1'b0;
                  if (r_do_wb) begin
                     r_rf_we    <= 1'b1;
                     r_rf_waddr <= r_rn_addr;
                     r_rf_wdata <= r_final;
                     r_state    <= WB;
                  end else begin
                     r_done  <= 1'b1;
                     r_state <= DONE;
                  end
               end
            end
            LDWR: begin
               if (w_cur_vld) begin
                  r_mem_req <= 1'b1;
                  r_state   <= XFER;
               end else if (r_do_wb) begin
                  r_rf_we    <= 1'b1;
                  r_rf_waddr <= r_rn_addr;
                  r_rf_wdata <= r_final;
                  r_state    <= WB;
               end else begin
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end
            end
            WB: begin
               r_done  <= 1'b1;
               r_state <= DONE;
            end
            DONE: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.rf_raddr  = ADDR'(w_cur_idx);
   assign bus.mem_wdata = (r_mem_req && r_mem_we) ? bus.rf_rdata : '0;
   assign bus.mem_addr  = r_addr;
   assign bus.mem_req   = r_mem_req;
   assign bus.mem_we    = r_mem_we;
   assign bus.rf_we     = r_rf_we;
   assign bus.rf_waddr  = r_rf_waddr;
   assign bus.rf_wdata  = r_rf_wdata;
   assign bus.pc_we     = r_pc_we;
   assign bus.pc_new    = r_pc_new;
   assign o_busy        = r_busy;
   assign o_done        = r_done;

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Directed bench for ldm_stm_seq: register file and memory are small fixed models.
module tb_ldm_stm_seq;
   logic        clk = 1'b0;
   logic        Rst;
   logic        start, is_load, pre, up, wback;
   logic [3:0]  rn_addr;
   logic [31:0] rn_data;
   logic [15:0] reg_list;
   logic        mem_ack_d;
   logic        busy, done;
   int          n_checks = 0;
   int          n_err = 0;

   ldm_stm_seq_if #(.ADDR(4), .SIZE(32)) bus ();

   // Register Ri reads as 0xA000_000i; memory word at A reads as 0xD000_0003 ^ (A << 8)
   assign bus.rf_rdata  = 32'hA000_0000 | 32'(bus.rf_raddr);
   assign bus.mem_rdata = 32'hD000_0003 ^ (bus.mem_addr << 8);
   assign bus.mem_ack   = mem_ack_d;

   ldm_stm_seq #(.ADDR(4), .SIZE(32)) dut (
      .clk        (clk),
      .Rst        (Rst),
      .i_start    (start),
      .i_is_load  (is_load),
      .i_pre      (pre),
      .i_up       (up),
      .i_wback    (wback),
      .i_rn_addr  (rn_addr),
      .i_rn_data  (rn_data),
      .i_reg_list (reg_list),
      .bus        (bus),
      .o_busy     (busy),
      .o_done     (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic launch(input logic ld, input logic p, input logic u, input logic w,
                         input logic [3:0] rn, input logic [31:0] rd, input logic [15:0] lst);
      is_load = ld; pre = p; up = u; wback = w;
      rn_addr = rn; rn_data = rd; reg_list = lst;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      Rst = 1'b1; start = 1'b0; is_load = 1'b0; pre = 1'b0; up = 1'b0; wback = 1'b0;
      rn_addr = 4'd0; rn_data = 32'd0; reg_list = 16'd0; mem_ack_d = 1'b0;
      tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_req", 32'(bus.mem_req), 32'd0);
      chk("rst_rfwe", 32'(bus.rf_we), 32'd0);
      chk("rst_pcwe", 32'(bus.pc_we), 32'd0);
      Rst = 1'b0;
      tick();

      // STMIA r0!, {r1-r3}, ack every cycle
      mem_ack_d = 1'b1;
      launch(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 32'h100, 16'h000E);
      chk("stm_setup_busy", 32'(busy), 32'd1);
      chk("stm_setup_req", 32'(bus.mem_req), 32'd0);
      tick();
      chk("stm1_req", 32'(bus.mem_req), 32'd1);
      chk("stm1_we", 32'(bus.mem_we), 32'd1);
      chk("stm1_addr", bus.mem_addr, 32'h100);
      chk("stm1_wdata", bus.mem_wdata, 32'hA000_0001);
      tick();
      chk("stm2_addr", bus.mem_addr, 32'h104);
      chk("stm2_wdata", bus.mem_wdata, 32'hA000_0002);
      tick();
      chk("stm3_addr", bus.mem_addr, 32'h108);
      chk("stm3_wdata", bus.mem_wdata, 32'hA000_0003);
      tick();
      chk("stm_wb_req", 32'(bus.mem_req), 32'd0);
      chk("stm_wb_we", 32'(bus.rf_we), 32'd1);
      chk("stm_wb_addr", 32'(bus.rf_waddr), 32'd0);
      chk("stm_wb_data", bus.rf_wdata, 32'h10C);
      tick();
      chk("stm_done", 32'(done), 32'd1);
      chk("stm_done_rfwe", 32'(bus.rf_we), 32'd0);
      tick();
      chk("stm_idle_done", 32'(done), 32'd0);
      chk("stm_idle_busy", 32'(busy), 32'd0);

      // LDMDB r13!, {r0, r1, pc}
      launch(1'b1, 1'b1, 1'b0, 1'b1, 4'd13, 32'h200, 16'h8003);
      tick();
      chk("ldb1_addr", bus.mem_addr, 32'h1F4);
      chk("ldb1_we", 32'(bus.mem_we), 32'd0);
      tick();
      chk("ldb1_req", 32'(bus.mem_req), 32'd0);
      chk("ldb1_rfwe", 32'(bus.rf_we), 32'd1);
      chk("ldb1_waddr", 32'(bus.rf_waddr), 32'd0);
      chk("ldb1_wdata", bus.rf_wdata, 32'hD001_F403);
      tick();
      chk("ldb2_addr", bus.mem_addr, 32'h1F8);
      tick();
      chk("ldb2_waddr", 32'(bus.rf_waddr), 32'd1);
      chk("ldb2_wdata", bus.rf_wdata, 32'hD001_F803);
      tick();
      chk("ldb3_addr", bus.mem_addr, 32'h1FC);
      tick();
      chk("ldb_pc_we", 32'(bus.pc_we), 32'd1);
      chk("ldb_pc_rfwe", 32'(bus.rf_we), 32'd0);
      chk("ldb_pc_new", bus.pc_new, 32'hD001_FC00);
      tick();
      chk("ldb_wb_we", 32'(bus.rf_we), 32'd1);
      chk("ldb_wb_addr", 32'(bus.rf_waddr), 32'd13);
      chk("ldb_wb_data", bus.rf_wdata, 32'h1F4);
      chk("ldb_wb_pcwe", 32'(bus.pc_we), 32'd0);
      tick();
      chk("ldb_done", 32'(done), 32'd1);
      tick();

      // LDMIA r2!, {r2}: loaded value wins, no writeback
      launch(1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 32'h40, 16'h0004);
      tick();
      chk("ldself_addr", bus.mem_addr, 32'h40);
      tick();
      chk("ldself_waddr", 32'(bus.rf_waddr), 32'd2);
      chk("ldself_wdata", bus.rf_wdata, 32'hD000_4003);
      tick();
      chk("ldself_done", 32'(done), 32'd1);
      chk("ldself_no_wb", 32'(bus.rf_we), 32'd0);
      tick();

      // STMIB with an empty list
      launch(1'b0, 1'b1, 1'b1, 1'b1, 4'd5, 32'h600, 16'h0000);
      chk("empty_setup_req", 32'(bus.mem_req), 32'd0);
      chk("empty_setup_done", 32'(done), 32'd0);
      tick();
      chk("empty_done", 32'(done), 32'd1);
      chk("empty_req", 32'(bus.mem_req), 32'd0);
      chk("empty_rfwe", 32'(bus.rf_we), 32'd0);
      tick();
      chk("empty_busy", 32'(busy), 32'd0);

      // STMIA r4, {r0-r2} with a 3-cycle ack stall on the second word
      launch(1'b0, 1'b0, 1'b1, 1'b0, 4'd4, 32'h300, 16'h0007);
      tick();
      chk("stall1_addr", bus.mem_addr, 32'h300);
      chk("stall1_wdata", bus.mem_wdata, 32'hA000_0000);
      tick();
      mem_ack_d = 1'b0;
      is_load = 1'b1; reg_list = 16'hFFFF; rn_data = 32'hDEAD_0000;
      start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("stall_req", 32'(bus.mem_req), 32'd1);
         chk("stall_addr", bus.mem_addr, 32'h304);
         chk("stall_wdata", bus.mem_wdata, 32'hA000_0001);
         tick();
         start = 1'b0;
      end
      mem_ack_d = 1'b1;
      chk("stall_hold_addr", bus.mem_addr, 32'h304);
      tick();
      chk("stall3_addr", bus.mem_addr, 32'h308);
      chk("stall3_wdata", bus.mem_wdata, 32'hA000_0002);
      tick();
      chk("stall_done", 32'(done), 32'd1);
      chk("stall_no_wb", 32'(bus.rf_we), 32'd0);
      tick();
      chk("stall_idle_busy", 32'(busy), 32'd0);
      tick();
      chk("stall_ignored_start", 32'(busy), 32'd0);
      chk("stall_ignored_req", 32'(bus.mem_req), 32'd0);

      // Reset in the middle of a 4-register LDM
      mem_ack_d = 1'b0;
      launch(1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 32'h500, 16'h00F0);
      tick();
      chk("abort_pre_req", 32'(bus.mem_req), 32'd1);
      #2 Rst = 1'b1;
      #1;
      chk("abort_req", 32'(bus.mem_req), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_addr", bus.mem_addr, 32'h0);
      chk("abort_rfwe", 32'(bus.rf_we), 32'd0);
      chk("abort_pcwe", 32'(bus.pc_we), 32'd0);
      tick();
      Rst = 1'b0;
      mem_ack_d = 1'b1;
      tick();
      chk("abort_idle_req", 32'(bus.mem_req), 32'd0);

      // Fresh LDMIA r3!, {r0} after the abort
      launch(1'b1, 1'b0, 1'b1, 1'b1, 4'd3, 32'h80, 16'h0001);
      tick();
      chk("fresh_addr", bus.mem_addr, 32'h80);
      tick();
      chk("fresh_waddr", 32'(bus.rf_waddr), 32'd0);
      chk("fresh_wdata", bus.rf_wdata, 32'hD000_8003);
      tick();
      chk("fresh_wb_addr", 32'(bus.rf_waddr), 32'd3);
      chk("fresh_wb_data", bus.rf_wdata, 32'h84);
      tick();
      chk("fresh_done", 32'(done), 32'd1);
      tick();
      chk("fresh_idle", 32'(busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
